// File: rtl/sram_banked_2p.sv
// sram_banked_2p: sky130 1rw1r macros tiled in columns and banks, with byte strobes,
// range errors and a 3-entry read response buffer. Optional macro: SRAM_WR_FWD_EN.

// Behavioural stand-in for the hard macro: port 0 writes, port 1 reads, both registered.
module sky130_sram_1kbyte_1rw1r_32x256_8 (
   input  logic        clk0,
   input  logic        csb0,
   input  logic        web0,
   input  logic [3:0]  wmask0,
   input  logic [7:0]  addr0,
   input  logic [31:0] din0,
   input  logic        clk1,
   input  logic        csb1,
   input  logic [7:0]  addr1,
   output logic [31:0] dout1
);
   logic [31:0] mem_q [256];
   logic [31:0] dout1_q;

   always_ff @(posedge clk0) begin
      if (!csb0 && !web0) begin
         for (int k = 0; k < 4; k++) begin
            if (wmask0[k]) mem_q[addr0][8*k +: 8] <= din0[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk1) begin
      if (!csb1) dout1_q <= mem_q[addr1];
   end

   assign dout1 = dout1_q;
endmodule

module sram_banked_2p #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 10,
   parameter int MEM_SIZE = 1 << ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_vld_i,
   output logic                  wr_rdy_o,
   input  logic [ADDR_W-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0]     wr_data_i,
   input  logic [DATA_W/8-1:0]   wr_strb_i,
   output logic                  wr_err_o,
   input  logic                  rd_vld_i,
   output logic                  rd_rdy_o,
   input  logic [ADDR_W-1:0]     rd_addr_i,
   output logic [DATA_W-1:0]     rd_data_o,
   output logic                  rd_err_o,
   output logic                  rd_data_vld_o,
   input  logic                  rd_data_rdy_i
);
   localparam int MACRO_W     = 32;
   localparam int MACRO_DEPTH = 256;
   localparam int COLS        = (DATA_W + MACRO_W - 1) / MACRO_W;
   localparam int BANKS       = (MEM_SIZE + MACRO_DEPTH - 1) / MACRO_DEPTH;
   localparam int PAD_W       = COLS * MACRO_W;
   localparam int STRB_W      = DATA_W / 8;
   localparam int PSTRB_W     = COLS * 4;
   localparam int BANK_W      = (ADDR_W > 8) ? ADDR_W - 8 : 1;

   // Valid/ready: a transfer happens on a rising edge where both valid and ready are 1;
   // rd_rdy_o comes from registered occupancy only, so it never depends on rd_data_rdy_i.
   logic                          wr_in_range, rd_in_range, rd_fire;
   logic [BANK_W-1:0]             wr_bank, rd_bank;
   logic [7:0]                    wr_row, rd_row;
   logic [PAD_W-1:0]              wdata_pad;
   logic [PSTRB_W-1:0]            wstrb_pad;
   logic [BANKS-1:0]              csb0, csb1;
   logic [BANKS-1:0][PAD_W-1:0]   dout1_all;
   logic [PAD_W-1:0]              rd_mux;
   logic [DATA_W-1:0]             rd_word;

   logic                          wr_err_q, wr_err_d;
   logic                          s1_vld_q, s1_vld_d;
   logic                          s1_err_q, s1_err_d;
   logic [BANK_W-1:0]             s1_bank_q, s1_bank_d;

   logic [DATA_W-1:0]             buf_data_q [3];
   logic [DATA_W-1:0]             buf_data_d [3];
   logic [2:0]                    buf_err_q, buf_err_d;
   logic [1:0]                    buf_wr_ptr_q, buf_wr_ptr_d;
   logic [1:0]                    buf_rd_ptr_q, buf_rd_ptr_d;
   logic [1:0]                    buf_cnt_q, buf_cnt_d;
   logic                          buf_push, buf_pop;

`ifdef SRAM_WR_FWD_EN
   logic                          s1_hit_q, s1_hit_d;
   logic [DATA_W-1:0]             s1_wdata_q, s1_wdata_d;
   logic [STRB_W-1:0]             s1_wstrb_q, s1_wstrb_d;
`endif

   generate
      if (ADDR_W > 8) begin : g_split
         assign wr_bank = wr_addr_i[ADDR_W-1:8];
         assign rd_bank = rd_addr_i[ADDR_W-1:8];
         assign wr_row  = wr_addr_i[7:0];
         assign rd_row  = rd_addr_i[7:0];
      end else begin : g_flat
         assign wr_bank = '0;
         assign rd_bank = '0;
         assign wr_row  = 8'(wr_addr_i);
         assign rd_row  = 8'(rd_addr_i);
      end
   endgenerate

   assign wr_rdy_o    = 1'b1;
   assign wr_err_o    = wr_err_q;
   assign wr_in_range = 32'(wr_addr_i) < 32'(MEM_SIZE);
   assign rd_in_range = 32'(rd_addr_i) < 32'(MEM_SIZE);
   assign rd_rdy_o    = ({2'b00, s1_vld_q} + {1'b0, buf_cnt_q}) < 3'd3;
   assign rd_fire     = rd_vld_i && rd_rdy_o;

   // Lanes beyond DATA_W stay at zero data / zero mask.
   always_comb begin
      wdata_pad = '0;
      wstrb_pad = '0;
      wdata_pad[DATA_W-1:0] = wr_data_i;
      wstrb_pad[STRB_W-1:0] = wr_strb_i;
      for (int b = 0; b < BANKS; b++) begin
         csb0[b] = !(wr_vld_i && wr_in_range && (wr_bank == BANK_W'(b)));
         csb1[b] = !(rd_fire && rd_in_range && (rd_bank == BANK_W'(b)));
      end
   end

   generate
      for (genvar b = 0; b < BANKS; b++) begin : g_bank
         for (genvar c = 0; c < COLS; c++) begin : g_col
            sky130_sram_1kbyte_1rw1r_32x256_8 u_macro (
               .clk0   (clk),
               .csb0   (csb0[b]),
               .web0   (csb0[b]),
               .wmask0 (wstrb_pad[4*c +: 4]),
               .addr0  (wr_row),
               .din0   (wdata_pad[MACRO_W*c +: MACRO_W]),
               .clk1   (clk),
               .csb1   (csb1[b]),
               .addr1  (rd_row),
               .dout1  (dout1_all[b][MACRO_W*c +: MACRO_W])
            );
         end
      end
   endgenerate

   always_comb begin
      wr_err_d  = wr_vld_i && !wr_in_range;
      s1_vld_d  = rd_fire;
      s1_err_d  = rd_fire && !rd_in_range;
      s1_bank_d = rd_bank;
`ifdef SRAM_WR_FWD_EN
      s1_hit_d   = rd_fire && wr_vld_i && wr_in_range && (rd_addr_i == wr_addr_i);
      s1_wdata_d = wr_data_i;
      s1_wstrb_d = wr_strb_i;
`endif
   end

   // Bank selection uses the registered S1 index so the mux lines up with macro dout.
   always_comb begin
      rd_mux = '0;
      for (int b = 0; b < BANKS; b++) begin
         if (s1_bank_q == BANK_W'(b)) rd_mux = dout1_all[b];
      end
      rd_word = s1_err_q ? '0 : rd_mux[DATA_W-1:0];
`ifdef SRAM_WR_FWD_EN
      for (int k = 0; k < STRB_W; k++) begin
         if (s1_hit_q && s1_wstrb_q[k]) rd_word[8*k +: 8] = s1_wdata_q[8*k +: 8];
      end
`endif
   end

   always_comb begin
      buf_push     = s1_vld_q;
      buf_pop      = (buf_cnt_q != 2'd0) && rd_data_rdy_i;
      buf_data_d   = buf_data_q;
      buf_err_d    = buf_err_q;
      buf_wr_ptr_d = buf_wr_ptr_q;
      buf_rd_ptr_d = buf_rd_ptr_q;
      if (buf_push) begin
         for (int i = 0; i < 3; i++) begin
            if (buf_wr_ptr_q == 2'(i)) begin
               buf_data_d[i] = rd_word;
               buf_err_d[i]  = s1_err_q;
            end
         end
         buf_wr_ptr_d = (buf_wr_ptr_q == 2'd2) ? 2'd0 : buf_wr_ptr_q + 2'd1;
      end
      if (buf_pop) buf_rd_ptr_d = (buf_rd_ptr_q == 2'd2) ? 2'd0 : buf_rd_ptr_q + 2'd1;
      buf_cnt_d = buf_cnt_q + 2'(buf_push) - 2'(buf_pop);
   end

   always_comb begin
      rd_data_o     = '0;
      rd_err_o      = 1'b0;
      rd_data_vld_o = buf_cnt_q != 2'd0;
      for (int i = 0; i < 3; i++) begin
         if (buf_rd_ptr_q == 2'(i)) begin
            rd_data_o = buf_data_q[i];
            rd_err_o  = buf_err_q[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_err_q     <= 1'b0;
         s1_vld_q     <= 1'b0;
         s1_err_q     <= 1'b0;
         s1_bank_q    <= '0;
         for (int i = 0; i < 3; i++) buf_data_q[i] <= '0;
         buf_err_q    <= '0;
         buf_wr_ptr_q <= '0;
         buf_rd_ptr_q <= '0;
         buf_cnt_q    <= '0;
`ifdef SRAM_WR_FWD_EN
         s1_hit_q     <= 1'b0;
         s1_wdata_q   <= '0;
         s1_wstrb_q   <= '0;
`endif
      end else begin
         wr_err_q     <= wr_err_d;
         s1_vld_q     <= s1_vld_d;
         s1_err_q     <= s1_err_d;
         s1_bank_q    <= s1_bank_d;
         buf_data_q   <= buf_data_d;
         buf_err_q    <= buf_err_d;
         buf_wr_ptr_q <= buf_wr_ptr_d;
         buf_rd_ptr_q <= buf_rd_ptr_d;
         buf_cnt_q    <= buf_cnt_d;
`ifdef SRAM_WR_FWD_EN
         s1_hit_q     <= s1_hit_d;
         s1_wdata_q   <= s1_wdata_d;
         s1_wstrb_q   <= s1_wstrb_d;
`endif
      end
   end

   // Occupancy gating guarantees a push never meets a full buffer.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(buf_push && !buf_pop && (buf_cnt_q == 2'd3)));

endmodule

// File: tb/tb_sram_banked_2p.sv
// Bench for sram_banked_2p (64-bit data, 10-bit address, 600 words): directed cases plus
// random traffic checked against a queue/array reference model.
module tb_sram_banked_2p;
   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 10;
   localparam int MEM_SIZE = 600;
   localparam int STRB_W   = DATA_W / 8;

   logic                clk;
   logic                rst;
   logic                wr_vld_i;
   logic                wr_rdy_o;
   logic [ADDR_W-1:0]   wr_addr_i;
   logic [DATA_W-1:0]   wr_data_i;
   logic [STRB_W-1:0]   wr_strb_i;
   logic                wr_err_o;
   logic                rd_vld_i;
   logic                rd_rdy_o;
   logic [ADDR_W-1:0]   rd_addr_i;
   logic [DATA_W-1:0]   rd_data_o;
   logic                rd_err_o;
   logic                rd_data_vld_o;
   logic                rd_data_rdy_i;

   sram_banked_2p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_SIZE(MEM_SIZE)) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_vld_i      (wr_vld_i),
      .wr_rdy_o      (wr_rdy_o),
      .wr_addr_i     (wr_addr_i),
      .wr_data_i     (wr_data_i),
      .wr_strb_i     (wr_strb_i),
      .wr_err_o      (wr_err_o),
      .rd_vld_i      (rd_vld_i),
      .rd_rdy_o      (rd_rdy_o),
      .rd_addr_i     (rd_addr_i),
      .rd_data_o     (rd_data_o),
      .rd_err_o      (rd_err_o),
      .rd_data_vld_o (rd_data_vld_o),
      .rd_data_rdy_i (rd_data_rdy_i)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // reference model: word array plus expected-response queue tagged with acceptance cycle
   logic [DATA_W-1:0] mem_m [1024];
   logic [DATA_W:0]   exp_q [$];
   int                acc_q [$];
   logic              prev_oob;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      logic [DATA_W:0]   e;
      logic [DATA_W-1:0] v;
      logic              exp_vld;
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
         prev_oob = 1'b0;
      end else begin
         exp_vld = (exp_q.size() > 0) && (acc_q[0] + 1 <= cyc);
         check_eq("wr_err", wr_err_o, prev_oob);
         check_eq("rd_rdy", rd_rdy_o, exp_q.size() < 3);
         check_eq("rd_vld", rd_data_vld_o, exp_vld);
         if (rd_data_vld_o && rd_data_rdy_i) begin
            if (exp_q.size() == 0) begin
               check_eq("pop_empty", rd_data_vld_o, 1'b0);
            end else begin
               e = exp_q.pop_front();
               void'(acc_q.pop_front());
               check_eq("rd_data", rd_data_o, e[DATA_W-1:0]);
               check_eq("rd_err", rd_err_o, e[DATA_W]);
            end
         end
         if (rd_vld_i && rd_rdy_o) begin
            v = (rd_addr_i < MEM_SIZE) ? mem_m[rd_addr_i] : '0;
`ifdef SRAM_WR_FWD_EN
            if (wr_vld_i && (wr_addr_i == rd_addr_i) && (wr_addr_i < MEM_SIZE)) begin
               for (int k = 0; k < STRB_W; k++)
                  if (wr_strb_i[k]) v[8*k +: 8] = wr_data_i[8*k +: 8];
            end
`endif
            exp_q.push_back({rd_addr_i >= MEM_SIZE, v});
            acc_q.push_back(cyc + 1);
         end
         if (wr_vld_i && (wr_addr_i < MEM_SIZE)) begin
            for (int k = 0; k < STRB_W; k++)
               if (wr_strb_i[k]) mem_m[wr_addr_i][8*k +: 8] = wr_data_i[8*k +: 8];
         end
         prev_oob = wr_vld_i && (wr_addr_i >= MEM_SIZE);
      end
   end

   // driver tasks
   task automatic drive(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input logic [STRB_W-1:0] ws, input logic rv, input logic [ADDR_W-1:0] ra,
                        input logic rr);
      wr_vld_i = wv; wr_addr_i = wa; wr_data_i = wd; wr_strb_i = ws;
      rd_vld_i = rv; rd_addr_i = ra; rd_data_rdy_i = rr;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input logic rr);
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, '0, rr);
   endtask

   task automatic read_hold(input logic [ADDR_W-1:0] a, input logic rr, input string tag);
      logic f;
      f = 1'b0;
      for (int i = 0; i < 20 && !f; i++) begin
         wr_vld_i = 1'b0; rd_vld_i = 1'b1; rd_addr_i = a; rd_data_rdy_i = rr;
         f = rd_rdy_o;
         @(posedge clk); #1;
      end
      rd_vld_i = 1'b0;
      check_eq(tag, f, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ADDR_W-1:0] wa, ra;
      logic              wv, rv;
      int                n;
      for (int i = 0; i < 1024; i++) mem_m[i] = '0;
      rst = 1'b1;
      wr_vld_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; wr_strb_i = '0;
      rd_vld_i = 1'b0; rd_addr_i = '0; rd_data_rdy_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_wr_err", wr_err_o, 1'b0);
      check_eq("rst_rd_vld", rd_data_vld_o, 1'b0);
      check_eq("rst_rd_err", rd_err_o, 1'b0);
      check_eq("rst_rd_data", rd_data_o, 64'h0);
      check_eq("rst_rd_rdy", rd_rdy_o, 1'b1);
      check_eq("wr_rdy", wr_rdy_o, 1'b1);
      rst = 1'b0;
      idle(2, 1'b1);

      for (int a = 0; a < MEM_SIZE; a++)
         drive(1'b1, ADDR_W'(a), {$urandom, $urandom}, 8'hFF, 1'b0, '0, 1'b1);

      // basic write then read, latency 2
      drive(1'b1, 10'h005, 64'h1122334455667788, 8'hFF, 1'b0, '0, 1'b1);
      drive(1'b0, '0, '0, '0, 1'b1, 10'h005, 1'b1);
      check_eq("lat_early_vld", rd_data_vld_o, 1'b0);
      rd_vld_i = 1'b0;
      @(posedge clk); #1;
      check_eq("lat2_vld", rd_data_vld_o, 1'b1);
      check_eq("lat2_data", rd_data_o, 64'h1122334455667788);
      check_eq("lat2_err", rd_err_o, 1'b0);
      idle(3, 1'b1);

      // strobed partial write at the end of bank 1
      drive(1'b1, 10'h1FF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, '0, 1'b1);
      drive(1'b1, 10'h1FF, 64'h0, 8'h0F, 1'b0, '0, 1'b1);
      drive(1'b1, 10'h1FF, 64'h0, 8'h00, 1'b0, '0, 1'b1);
      drive(1'b0, '0, '0, '0, 1'b1, 10'h1FF, 1'b1);
      rd_vld_i = 1'b0;
      @(posedge clk); #1;
      check_eq("strb_data", rd_data_o, 64'hFFFF_FFFF_0000_0000);
      idle(3, 1'b1);

      // out-of-range write and read
      drive(1'b1, 10'h300, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b0, '0, 1'b1);
      check_eq("oob_wr_err", wr_err_o, 1'b1);
      drive(1'b0, '0, '0, '0, 1'b1, 10'h300, 1'b1);
      check_eq("oob_wr_err_pulse", wr_err_o, 1'b0);
      rd_vld_i = 1'b0;
      @(posedge clk); #1;
      check_eq("oob_rd_data", rd_data_o, 64'h0);
      check_eq("oob_rd_err", rd_err_o, 1'b1);
      drive(1'b0, '0, '0, '0, 1'b1, 10'h000, 1'b1);
      drive(1'b0, '0, '0, '0, 1'b1, 10'h100, 1'b1);
      drive(1'b0, '0, '0, '0, 1'b1, 10'h200, 1'b1);
      idle(4, 1'b1);

      // backpressure: only three reads accepted while the consumer stalls
      read_hold(10'd0, 1'b0, "bp_acc0");
      read_hold(10'd1, 1'b0, "bp_acc1");
      read_hold(10'd2, 1'b0, "bp_acc2");
      check_eq("bp_rdy_low", rd_rdy_o, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, '0, 1'b1, 10'd3, 1'b0);
      check_eq("bp_hold_data", rd_data_o, mem_m[0]);
      read_hold(10'd3, 1'b1, "bp_acc3");
      read_hold(10'd4, 1'b1, "bp_acc4");
      read_hold(10'd5, 1'b1, "bp_acc5");
      idle(4, 1'b1);

      // back-to-back reads across a full bank
      for (int a = 0; a < 256; a++) begin
         check_eq("b2b_rdy", rd_rdy_o, 1'b1);
         drive(1'b0, '0, '0, '0, 1'b1, ADDR_W'(a), 1'b1);
      end
      idle(4, 1'b1);

`ifdef SRAM_WR_FWD_EN
      drive(1'b1, 10'h010, {16{4'hA}}, 8'hFF, 1'b0, '0, 1'b1);
      drive(1'b1, 10'h010, {16{4'h5}}, 8'hF0, 1'b1, 10'h010, 1'b1);
      wr_vld_i = 1'b0; rd_vld_i = 1'b0;
      @(posedge clk); #1;
      check_eq("fwd_data", rd_data_o, 64'h5555_5555_AAAA_AAAA);
      idle(3, 1'b1);
`endif

      // random mixed traffic
      for (int i = 0; i < 3000; i++) begin
         wv = $urandom_range(1, 0) == 1;
         rv = $urandom_range(3, 0) != 0;
         wa = ADDR_W'($urandom_range(1023, 0));
         ra = ADDR_W'($urandom_range(1023, 0));
`ifdef SRAM_WR_FWD_EN
         if ($urandom_range(7, 0) == 0) ra = wa;
`else
         if (wv && rv && (wa == ra)) rv = 1'b0;
`endif
         drive(wv, wa, {$urandom, $urandom}, STRB_W'($urandom), rv, ra,
               $urandom_range(9, 0) < 7);
      end
      idle(6, 1'b1);

      // reset with reads in flight: nothing may come out afterwards
      drive(1'b0, '0, '0, '0, 1'b1, 10'd7, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 10'd8, 1'b0);
      rd_vld_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("midrst_vld", rd_data_vld_o, 1'b0);
      check_eq("midrst_rdy", rd_rdy_o, 1'b1);
      rst = 1'b0;
      idle(8, 1'b1);

      n = 0;
      while (exp_q.size() > 0 && n < 50) begin
         idle(1, 1'b1);
         n++;
      end
      check_eq("drain", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sram_banked_2p.md
Name: sram_banked_2p

Overview:
- Parametrised successor to the single-port sky130 SRAM wrapper; tiles sky130_sram_1kbyte_1rw1r_32x256_8 macros in columns (width) and banks (depth).
- Write traffic uses macro port 0 and read traffic uses macro port 1, so one write and one read can complete per cycle.
- Adds byte strobes, out-of-range error reporting, a registered bank-select read mux and a 3-entry output buffer with valid/ready backpressure.
- Sits between bus-side controllers (DMA, FIFOs, scratchpads) and the hard macros.

Parameters:
- DATA_W, 64, data width; must be a multiple of 8.
- ADDR_W, 10, word address width.
- MEM_SIZE, 1<<ADDR_W, number of words implemented; must be ≤ 2^ADDR_W.
- MACRO_W, 32, macro data width; fixed, not overridable.
- MACRO_DEPTH, 256, macro word count; fixed, not overridable.
- Derived: COLS = ceil(DATA_W/32), BANKS = ceil(MEM_SIZE/256).

Ports:
- clk  in  1  clock, rising edge; drives clk0 and clk1 of every macro.
- rst  in  1  asynchronous reset, active-high.
- wr_vld_i  in  1  write request.
- wr_rdy_o  out  1  write accept; constant 1.
- wr_addr_i  in  ADDR_W  write word address.
- wr_data_i  in  DATA_W  write data.
- wr_strb_i  in  DATA_W/8  byte enables; bit k covers wr_data_i[8k+7:8k].
- wr_err_o  out  1  pulse: write address ≥ MEM_SIZE.
- rd_vld_i  in  1  read request.
- rd_rdy_o  out  1  read accept.
- rd_addr_i  in  ADDR_W  read word address.
- rd_data_o  out  DATA_W  read data, head of output buffer.
- rd_err_o  out  1  sideband of head entry: address was ≥ MEM_SIZE.
- rd_data_vld_o  out  1  output buffer non-empty.
- rd_data_rdy_i  in  1  consumer ready.

Behaviour:
- Reset values:
  - wr_err_o=0, rd_data_vld_o=0, rd_err_o=0, rd_data_o=0.
  - S1 stage cleared; output buffer emptied (count=0, pointers=0).
  - rd_rdy_o=1 after reset.
  - Macro contents are not reset.
- Address split:
  - Bank = addr[ADDR_W-1:8]; macro row = addr[7:0].
  - When ADDR_W ≤ 8 there is a single bank with row = addr zero-extended.
- Write path:
  - Accepted every cycle that wr_vld_i=1.
  - In-range write: csb0=0 and web0=0 only in the addressed bank, all columns.
  - wmask0 of column c = wr_strb_i[4c+3:4c]; byte lanes beyond DATA_W are tied to mask 0.
  - Out-of-range write: no macro is selected; wr_err_o=1 on the following cycle for one cycle.
  - All-zero strobe: the write is performed with mask 0, so memory is unchanged; not an error.
- Read acceptance: fire = rd_vld_i & rd_rdy_o.
  - rd_rdy_o = (s1_vld + buf_cnt) < 3.
  - rd_rdy_o depends only on registered state, never combinationally on rd_data_rdy_i.
- Read pipeline:
  - Cycle T (fire): csb1=0 and addr1=row on the addressed bank only. S1 registers vld, bank index and err=(addr ≥ MEM_SIZE).
  - Cycle T+1: macro dout1 is muxed using the registered S1 bank index (an out-of-range read yields 0 data). The result is pushed into the output buffer at the end of T+1.
  - rd_data_vld_o rises at T+2; minimum read latency is 2 cycles.
- Output buffer:
  - 3-entry FIFO of {data, err}.
  - Pop when rd_data_vld_o & rd_data_rdy_i.
  - Push and pop in the same cycle leave the count unchanged.
  - Overflow is impossible by construction; an assertion checks buf_cnt ≤ 3.
- Throughput: with rd_data_rdy_i held at 1, one read per cycle indefinitely. With rd_data_rdy_i held at 0, exactly 3 reads are accepted and then rd_rdy_o=0.
- Held outputs: while rd_data_vld_o=1 and rd_data_rdy_i=0, rd_data_o and rd_err_o hold stable.
- Ordering: read responses are returned strictly in acceptance order.
- Reset mid-operation: in-flight reads are discarded, and no response is produced for them after reset.

Optional Feature:
- Macro SRAM_WR_FWD_EN.
- Defined:
  - A read accepted in the same cycle as an in-range write to the same address returns the write-merged data: new bytes where the strobe is set, macro bytes elsewhere.
  - S1 registers a hit flag, the write data and the strobes; the merge is applied at T+1.
- Undefined: same-cycle same-address read data is the raw macro output and is unspecified; the bench must not check it.
- All other behaviour is identical in both builds.

Test Plan:
- Write 0x1122334455667788 to addr 0x005, then read 0x005 → rd_data_vld_o at T+2, data 0x1122334455667788, rd_err_o=0.
- Write full word 0xFFFF_FFFF_FFFF_FFFF to 0x1FF, then write 0x0 with wr_strb_i=0x0F to 0x1FF, then read → 0xFFFF_FFFF_0000_0000. This also checks the bank-1 boundary.
- With MEM_SIZE=600, write to 0x300 → wr_err_o pulses once and no macro csb0 goes low. A read of 0x300 returns data 0 with rd_err_o=1.
- rd_data_rdy_i=0, rd_vld_i=1 held for addrs 0..5 → only 0,1,2 are accepted and rd_rdy_o=0. Release rd_data_rdy_i → data for 0,1,2 in order, then 3,4,5 follow at one per cycle.
- Back-to-back reads of addrs 0..255 with rd_data_rdy_i=1 → 256 responses in consecutive cycles, no bubbles.
- SRAM_WR_FWD_EN: addr 0x010 holds 0xAAAA…; same-cycle write of 0x5555… with strb 0xF0 plus read of 0x010 → 0x55555555_AAAAAAAA.
